// File: rtl/prng_seed_collector.sv
// prng_seed_collector: PRNG-side consumer of the TRNG entropy holding register.
// On a reseed request it gathers SEED_BLOCKS EHR words, acknowledging each with
// a one-cycle read pulse, then offers the concatenated seed on valid/ready.
// Health errors or a per-block wait timeout abort the collection; the seed
// buffer is zeroized after hand-off or abort.
module prng_seed_collector #(
    parameter int EHR_WIDTH   = 192,
    parameter int SEED_BLOCKS = 2,
    parameter int TIMEOUT_W   = 16
) (
    input  logic                             rng_clk,
    input  logic                             rst,
    input  logic                             seed_req,
    input  logic                             trng_prng_ehr_valid,
    input  logic [EHR_WIDTH-1:0]             trng_prng_ehr_data,
    input  logic                             trng_err,
    input  logic [TIMEOUT_W-1:0]             timeout_val,
    output logic                             prng_trng_ehr_rd,
    output logic                             prng_busy,
    output logic                             seed_valid,
    input  logic                             seed_ready,
    output logic [EHR_WIDTH*SEED_BLOCKS-1:0] seed_data,
    output logic                             seed_err,
    output logic [7:0]                       blocks_cnt
);

    localparam logic [7:0]           LAST_CNT = 8'(SEED_BLOCKS);
    localparam logic [TIMEOUT_W-1:0] TMO_ONE  = TIMEOUT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EHR,
        READ,
        GAP,
        OFFER,
        ERR
    } state_t;

    state_t               state;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 tmo_hit;

    // Timeout fires on the last permitted wait cycle; a zero limit disables it
    always_comb begin
        tmo_hit = (timeout_val != '0) && (tmo_cnt == (timeout_val - TMO_ONE));
    end

    // Collection FSM; every output is registered and updated with the state
    always_ff @(posedge rng_clk) begin
        if (rst) begin
            state            <= IDLE;
            tmo_cnt          <= '0;
            prng_trng_ehr_rd <= 1'b0;
            prng_busy        <= 1'b0;
            seed_valid       <= 1'b0;
            seed_data        <= '0;
            seed_err         <= 1'b0;
            blocks_cnt       <= '0;
        end else begin
            prng_trng_ehr_rd <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (seed_req) begin
                        seed_err   <= 1'b0;
                        blocks_cnt <= '0;
                        tmo_cnt    <= '0;
                        prng_busy  <= 1'b1;
                        state      <= WAIT_EHR;
                    end
                end

                WAIT_EHR: begin
                    if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                    if (trng_err) begin
                        state <= ERR;
                    end else if (tmo_hit && !trng_prng_ehr_valid) begin
                        state <= ERR;
                    end else if (trng_prng_ehr_valid) begin
                        // Slot select by compare keeps the write index in range
                        for (int unsigned k = 0; k < SEED_BLOCKS; k++) begin
                            if (blocks_cnt == 8'(k)) begin
                                seed_data[k*EHR_WIDTH +: EHR_WIDTH] <= trng_prng_ehr_data;
                            end
                        end
                        blocks_cnt       <= blocks_cnt + 8'd1;
                        prng_trng_ehr_rd <= 1'b1;
                        state            <= READ;
                    end
                end

                READ: begin
                    if (blocks_cnt == LAST_CNT) begin
                        seed_valid <= 1'b1;
                        state      <= OFFER;
                    end else begin
                        state <= GAP;
                    end
                end

                GAP: begin
                    if (trng_err) begin
                        state <= ERR;
                    end else if (!trng_prng_ehr_valid) begin
                        tmo_cnt <= '0;
                        state   <= WAIT_EHR;
                    end
                end

                OFFER: begin
                    if (seed_valid && seed_ready) begin
                        seed_valid <= 1'b0;
                        seed_data  <= '0;
                        blocks_cnt <= '0;
                        prng_busy  <= 1'b0;
                        state      <= IDLE;
                    end
                end

                ERR: begin
                    seed_data  <= '0;
                    blocks_cnt <= '0;
                    seed_err   <= 1'b1;
                    prng_busy  <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prng_seed_collector.sv
// tb_prng_seed_collector: directed scoreboard bench for prng_seed_collector.
module tb_prng_seed_collector;

    localparam int EW = 192;
    localparam int SB = 2;
    localparam int TW = 16;
    localparam int SW = EW * SB;

    logic          rng_clk = 1'b0;
    logic          rst;
    logic          seed_req;
    logic          ehr_valid;
    logic [EW-1:0] ehr_data;
    logic          trng_err;
    logic [TW-1:0] timeout_val;
    logic          seed_ready;
    logic          prng_trng_ehr_rd;
    logic          prng_busy;
    logic          seed_valid;
    logic [SW-1:0] seed_data;
    logic          seed_err;
    logic [7:0]    blocks_cnt;

    int n_checks   = 0;
    int n_fail     = 0;
    int rd_pulses  = 0;
    int seeds_seen = 0;
    int seeds_sent = 0;
    int base;
    logic [SW-1:0] exp_q[$];

    prng_seed_collector #(
        .EHR_WIDTH  (EW),
        .SEED_BLOCKS(SB),
        .TIMEOUT_W  (TW)
    ) dut (
        .rng_clk            (rng_clk),
        .rst                (rst),
        .seed_req           (seed_req),
        .trng_prng_ehr_valid(ehr_valid),
        .trng_prng_ehr_data (ehr_data),
        .trng_err           (trng_err),
        .timeout_val        (timeout_val),
        .prng_trng_ehr_rd   (prng_trng_ehr_rd),
        .prng_busy          (prng_busy),
        .seed_valid         (seed_valid),
        .seed_ready         (seed_ready),
        .seed_data          (seed_data),
        .seed_err           (seed_err),
        .blocks_cnt         (blocks_cnt)
    );

    always #5 rng_clk = ~rng_clk;

    function automatic logic [EW-1:0] blk(input logic [7:0] b);
        return {(EW/8){b}};
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endfunction

    function automatic void chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endfunction

    function automatic void chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endfunction

    function automatic void chkw(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endfunction

    // Monitor: counts rd pulses, pops the scoreboard on every seed hand-off
    always @(negedge rng_clk) begin
        if (prng_trng_ehr_rd === 1'b1) rd_pulses++;
        if (rst === 1'b0) begin
            if (seed_valid === 1'b1 && seed_ready === 1'b1) begin
                seeds_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_seed: got %h required no hand-off", seed_data);
                end else begin
                    chkw("seed_handoff", seed_data, exp_q.pop_front());
                end
            end
            if (prng_busy === 1'b0) begin
                chkw("idle_data_zero", seed_data, '0);
                chk8("idle_cnt_zero", blocks_cnt, 8'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge rng_clk);
        #1;
    endtask

    task automatic expect_seed(input logic [EW-1:0] b0, input logic [EW-1:0] b1);
        exp_q.push_back({b1, b0});
        seeds_sent++;
    endtask

    task automatic wait_rd(input string name);
        int k = 0;
        while (prng_trng_ehr_rd !== 1'b1 && k < 50) begin
            tick(1);
            k++;
        end
        n_checks++;
        if (prng_trng_ehr_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: rd=%b after 50 cycles, required 1", name, prng_trng_ehr_rd);
        end
    endtask

    // Present one block, drop valid the cycle after rd, then one idle cycle
    task automatic feed_block(input logic [EW-1:0] d, input string name);
        ehr_valid = 1'b1;
        ehr_data  = d;
        tick(1);
        wait_rd(name);
        tick(1);
        ehr_valid = 1'b0;
        tick(1);
    endtask

    // Fastest two-block collection: returns at the first OFFER cycle (cycle 6)
    task automatic collect_fast(input logic [EW-1:0] b0, input logic [EW-1:0] b1);
        seed_req  = 1'b1;
        ehr_valid = 1'b1;
        ehr_data  = b0;
        tick(1);
        seed_req = 1'b0;
        chk1("busy_after_req", prng_busy, 1'b1);
        tick(1);
        chk1("rd_first_cycle2", prng_trng_ehr_rd, 1'b1);
        tick(1);
        ehr_valid = 1'b0;
        chk1("rd_single_cycle", prng_trng_ehr_rd, 1'b0);
        tick(1);
        ehr_valid = 1'b1;
        ehr_data  = b1;
        tick(1);
        chk1("rd_second_cycle5", prng_trng_ehr_rd, 1'b1);
        tick(1);
        ehr_valid = 1'b0;
        chk1("seed_valid_cycle6", seed_valid, 1'b1);
        chkw("seed_data_offer", seed_data, {b1, b0});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2ms, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        seed_req    = 1'b0;
        ehr_valid   = 1'b0;
        ehr_data    = '0;
        trng_err    = 1'b0;
        timeout_val = '0;
        seed_ready  = 1'b1;
        tick(2);
        chk1("reset_rd", prng_trng_ehr_rd, 1'b0);
        chk1("reset_busy", prng_busy, 1'b0);
        chk1("reset_valid", seed_valid, 1'b0);
        chk1("reset_err", seed_err, 1'b0);
        chk8("reset_cnt", blocks_cnt, 8'd0);
        chkw("reset_data", seed_data, '0);
        rst = 1'b0;
        tick(1);

        // Normal collection
        base = rd_pulses;
        expect_seed(blk(8'hA5), blk(8'h3C));
        collect_fast(blk(8'hA5), blk(8'h3C));
        tick(1);
        chk1("normal_valid_one_cycle", seed_valid, 1'b0);
        chkw("normal_data_zeroized", seed_data, '0);
        chk1("normal_err", seed_err, 1'b0);
        chk1("normal_idle", prng_busy, 1'b0);
        chki("normal_rd_count", rd_pulses - base, 2);

        // Backpressure
        seed_ready = 1'b0;
        base = rd_pulses;
        expect_seed(blk(8'h11), blk(8'h22));
        collect_fast(blk(8'h11), blk(8'h22));
        for (int i = 0; i < 10; i++) begin
            chk1("bp_valid_held", seed_valid, 1'b1);
            chkw("bp_data_stable", seed_data, {blk(8'h22), blk(8'h11)});
            chki("bp_no_extra_rd", rd_pulses - base, 2);
            tick(1);
        end
        seed_ready = 1'b1;
        tick(1);
        chk1("bp_idle_after_ready", prng_busy, 1'b0);
        chk1("bp_valid_dropped", seed_valid, 1'b0);

        // Stale valid held in GAP
        base = rd_pulses;
        expect_seed(blk(8'hC3), blk(8'h5A));
        seed_req  = 1'b1;
        ehr_valid = 1'b1;
        ehr_data  = blk(8'hC3);
        tick(1);
        seed_req = 1'b0;
        tick(1);
        chk1("stale_rd_block0", prng_trng_ehr_rd, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk1("stale_no_rd", prng_trng_ehr_rd, 1'b0);
            chk8("stale_cnt", blocks_cnt, 8'd1);
            chk1("stale_busy", prng_busy, 1'b1);
        end
        tick(1);
        ehr_valid = 1'b0;
        tick(1);
        chki("stale_one_rd", rd_pulses - base, 1);
        feed_block(blk(8'h5A), "stale_block1_rd");
        chki("stale_total_rd", rd_pulses - base, 2);

        // Timeout of 8 cycles
        base        = rd_pulses;
        timeout_val = TW'(8);
        seed_req    = 1'b1;
        tick(1);
        seed_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk1("tmo_waiting_busy", prng_busy, 1'b1);
            chk1("tmo_waiting_no_err", seed_err, 1'b0);
            tick(1);
        end
        chk1("tmo_err_state_busy", prng_busy, 1'b1);
        chk1("tmo_err_not_early", seed_err, 1'b0);
        tick(1);
        chk1("tmo_seed_err", seed_err, 1'b1);
        chk1("tmo_idle", prng_busy, 1'b0);
        chk1("tmo_no_valid", seed_valid, 1'b0);
        chki("tmo_no_rd", rd_pulses - base, 0);

        // Timeout disabled
        timeout_val = '0;
        seed_req    = 1'b1;
        tick(1);
        seed_req = 1'b0;
        chk1("req_clears_err", seed_err, 1'b0);
        tick(1000);
        chk1("notmo_busy", prng_busy, 1'b1);
        chk1("notmo_no_err", seed_err, 1'b0);
        chki("notmo_no_rd", rd_pulses - base, 0);
        expect_seed(blk(8'hB0), blk(8'hB1));
        feed_block(blk(8'hB0), "notmo_b0_rd");
        feed_block(blk(8'hB1), "notmo_b1_rd");
        chki("notmo_rd_count", rd_pulses - base, 2);

        // Health error together with valid during block 1
        base     = rd_pulses;
        seed_req = 1'b1;
        ehr_valid = 1'b1;
        ehr_data  = blk(8'hC0);
        tick(1);
        seed_req = 1'b0;
        tick(1);
        chk1("herr_rd_block0", prng_trng_ehr_rd, 1'b1);
        tick(1);
        ehr_valid = 1'b0;
        tick(1);
        chk8("herr_partial_cnt", blocks_cnt, 8'd1);
        chkw("herr_partial_data", seed_data, SW'(blk(8'hC0)));
        ehr_valid = 1'b1;
        ehr_data  = blk(8'hC1);
        trng_err  = 1'b1;
        tick(1);
        chk1("herr_no_rd", prng_trng_ehr_rd, 1'b0);
        trng_err  = 1'b0;
        ehr_valid = 1'b0;
        tick(1);
        chk1("herr_seed_err", seed_err, 1'b1);
        chkw("herr_data_zero", seed_data, '0);
        chk1("herr_idle", prng_busy, 1'b0);
        chk8("herr_cnt_zero", blocks_cnt, 8'd0);
        chki("herr_rd_count", rd_pulses - base, 1);

        base = rd_pulses;
        expect_seed(blk(8'hD0), blk(8'hD1));
        seed_req = 1'b1;
        tick(1);
        seed_req = 1'b0;
        chk1("herr_err_cleared", seed_err, 1'b0);
        chk8("herr_cnt_cleared", blocks_cnt, 8'd0);
        chk1("herr_restart_busy", prng_busy, 1'b1);
        feed_block(blk(8'hD0), "herr_d0_rd");
        feed_block(blk(8'hD1), "herr_d1_rd");
        chki("herr_fresh_rd_count", rd_pulses - base, 2);

        // Reset while in GAP with block 0 captured
        base      = rd_pulses;
        seed_req  = 1'b1;
        ehr_valid = 1'b1;
        ehr_data  = blk(8'hE0);
        tick(1);
        seed_req = 1'b0;
        tick(2);
        chk1("rstgap_busy", prng_busy, 1'b1);
        chk8("rstgap_cnt", blocks_cnt, 8'd1);
        chkw("rstgap_data", seed_data, SW'(blk(8'hE0)));
        rst = 1'b1;
        tick(1);
        chk1("rstgap_rd", prng_trng_ehr_rd, 1'b0);
        chk1("rstgap_busy0", prng_busy, 1'b0);
        chk1("rstgap_valid0", seed_valid, 1'b0);
        chk1("rstgap_err0", seed_err, 1'b0);
        chk8("rstgap_cnt0", blocks_cnt, 8'd0);
        chkw("rstgap_data0", seed_data, '0);
        rst       = 1'b0;
        ehr_valid = 1'b0;
        tick(2);
        chk1("rstgap_stays_idle", prng_busy, 1'b0);
        chki("rstgap_rd_count", rd_pulses - base, 1);

        // seed_req pulses during WAIT_EHR are ignored
        base = rd_pulses;
        expect_seed(blk(8'hF0), blk(8'hF1));
        seed_req = 1'b1;
        tick(1);
        seed_req = 1'b0;
        feed_block(blk(8'hF0), "ignreq_f0_rd");
        seed_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk8("ignreq_cnt", blocks_cnt, 8'd1);
            chk1("ignreq_busy", prng_busy, 1'b1);
            chk1("ignreq_no_rd", prng_trng_ehr_rd, 1'b0);
        end
        seed_req = 1'b0;
        feed_block(blk(8'hF1), "ignreq_f1_rd");
        chki("ignreq_rd_count", rd_pulses - base, 2);

        tick(3);
        chki("scoreboard_drained", exp_q.size(), 0);
        chki("seed_handoffs", seeds_seen, seeds_sent);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
